// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// ---------------------------------------------------------------------------
// Pixel-column / line sequencer for the VGA display path. Produces the sync
// pulses, display enable, current pixel coordinates and a look-ahead fetch
// request so the pixel source can deliver data FETCH_LEAD cycles early.
//
// Ports
//   CLK         pixel clock
//   Reset       asynchronous, active-low reset
//   Enable      run timing; low blanks the display and restarts the frame
//   HSync       horizontal sync (asserted level = SYNC_POL)
//   VSync       vertical sync   (asserted level = SYNC_POL)
//   DispEn      visible pixel this cycle
//   PixX/PixY   current column / line
//   FetchReq    request pixel (FetchX, FetchY) now
//   FetchX/Y    coordinate being requested
//   LineStart   one-cycle pulse at column 0
//   FrameStart  one-cycle pulse at column 0 of line 0
//   HPhase      horizontal phase state: 0 ACTIVE, 1 FP, 2 SYNC, 3 BP
//   VPhase      vertical phase state, same encoding
//
// Timing model: every output is a flop, and every output value seen in a
// cycle describes the (Col, Row) held in that same cycle. To get that, all
// registered outputs are computed from the next-state counters/phases rather
// than from the current registers.
//
// Handshake: FetchReq is a one-way strobe with no ready. The pixel source has
// no back-pressure and must accept every request in the cycle it is raised;
// the matching pixel is shown exactly FETCH_LEAD cycles later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_timing_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int FETCH_LEAD = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Enable,
  output logic       HSync,
  output logic       VSync,
  output logic       DispEn,
  output logic [9:0] PixX,
  output logic [9:0] PixY,
  output logic       FetchReq,
  output logic [9:0] FetchX,
  output logic [9:0] FetchY,
  output logic       LineStart,
  output logic       FrameStart,
  output logic [1:0] HPhase,
  output logic [1:0] VPhase
);

  // Phase encoding shared by both FSMs.
  localparam logic [1:0] PH_ACTIVE = 2'd0;
  localparam logic [1:0] PH_FP     = 2'd1;
  localparam logic [1:0] PH_SYNC   = 2'd2;
  localparam logic [1:0] PH_BP     = 2'd3;

  // 11-bit arithmetic so Col+FETCH_LEAD cannot overflow.
  localparam logic [10:0] H_TOTAL     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOTAL     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] H_FP_START  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SY_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_FP_START  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SY_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_BP_START  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] LEAD        = 11'(FETCH_LEAD);
  localparam logic        SYNC_ON     = (SYNC_POL != 0);

  logic [10:0] col, row;
  logic [10:0] col_nxt, row_nxt;
  logic        col_wrap;
  logic        run;          // high once the first post-restart cycle is shown
  logic        hold;         // counters parked at 0 this cycle
  logic [1:0]  hphase, vphase;
  logic [1:0]  hphase_nxt, vphase_nxt;
  logic [10:0] fetch_sum;
  logic [10:0] fetch_x_nxt, fetch_y_nxt;
  logic        fetch_req_nxt;

  // While disabled, and on the first enabled cycle after reset or a disable
  // gap, the counters sit at (0,0); only the registered outputs differ.
  assign hold = !Enable || !run;

  // Counters: registered wrap at H_TOTAL-1 / V_TOTAL-1.
  always_comb begin
    col_nxt  = col;
    row_nxt  = row;
    col_wrap = 1'b0;
    if (hold) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (col == H_TOTAL - 11'd1) begin
      col_nxt  = '0;
      col_wrap = 1'b1;
      row_nxt  = (row == V_TOTAL - 11'd1) ? 11'd0 : row + 11'd1;
    end else begin
      col_nxt = col + 11'd1;
    end
  end

  // Horizontal phase FSM, stepped by the column about to be held.
  always_comb begin
    hphase_nxt = hphase;
    if (hold) begin
      hphase_nxt = PH_ACTIVE;
    end else begin
      case (hphase)
        PH_ACTIVE: if (col_nxt == H_FP_START) hphase_nxt = PH_FP;
        PH_FP:     if (col_nxt == H_SY_START) hphase_nxt = PH_SYNC;
        PH_SYNC:   if (col_nxt == H_BP_START) hphase_nxt = PH_BP;
        PH_BP:     if (col_wrap)              hphase_nxt = PH_ACTIVE;
        default:   hphase_nxt = PH_ACTIVE;
      endcase
    end
  end

  // Vertical phase FSM: only moves on the column wrap, so VSync edges land
  // on Col==0.
  always_comb begin
    vphase_nxt = vphase;
    if (hold) begin
      vphase_nxt = PH_ACTIVE;
    end else if (col_wrap) begin
      case (vphase)
        PH_ACTIVE: if (row_nxt == V_FP_START) vphase_nxt = PH_FP;
        PH_FP:     if (row_nxt == V_SY_START) vphase_nxt = PH_SYNC;
        PH_SYNC:   if (row_nxt == V_BP_START) vphase_nxt = PH_BP;
        PH_BP:     if (row_nxt == 11'd0)      vphase_nxt = PH_ACTIVE;
        default:   vphase_nxt = PH_ACTIVE;
      endcase
    end
  end

  // Look-ahead coordinate. Spilling past the line end targets the next line,
  // and past the last line targets line 0 of the next frame.
  always_comb begin
    fetch_sum = col_nxt + LEAD;
    if (fetch_sum >= H_TOTAL) begin
      fetch_x_nxt = fetch_sum - H_TOTAL;
      fetch_y_nxt = (row_nxt == V_TOTAL - 11'd1) ? 11'd0 : row_nxt + 11'd1;
    end else begin
      fetch_x_nxt = fetch_sum;
      fetch_y_nxt = row_nxt;
    end
    fetch_req_nxt = Enable && (fetch_x_nxt < H_FP_START) && (fetch_y_nxt < V_FP_START);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      col        <= '0;
      row        <= '0;
      run        <= 1'b0;
      hphase     <= PH_ACTIVE;
      vphase     <= PH_ACTIVE;
      HSync      <= ~SYNC_ON;
      VSync      <= ~SYNC_ON;
      DispEn     <= 1'b0;
      FetchReq   <= 1'b0;
      FetchX     <= '0;
      FetchY     <= '0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      col        <= col_nxt;
      row        <= row_nxt;
      run        <= Enable;
      hphase     <= hphase_nxt;
      vphase     <= vphase_nxt;
      HSync      <= (hphase_nxt == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
      VSync      <= (vphase_nxt == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
      DispEn     <= Enable && (hphase_nxt == PH_ACTIVE) && (vphase_nxt == PH_ACTIVE);
      FetchReq   <= fetch_req_nxt;
      FetchX     <= fetch_x_nxt[9:0];
      FetchY     <= fetch_y_nxt[9:0];
      LineStart  <= Enable && (col_nxt == 11'd0);
      FrameStart <= Enable && (col_nxt == 11'd0) && (row_nxt == 11'd0);
    end
  end

  assign PixX   = col[9:0];
  assign PixY   = row[9:0];
  assign HPhase = hphase;
  assign VPhase = vphase;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl
// ---------------------------------------------------------------------------
// Bench for vga_timing_ctrl. Instance "a" uses the default 640x480 timing
// with active-low syncs; instance "b" uses a small 16x8 raster with
// active-high syncs so whole frames fit in a short run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_timing_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, en_a, rst_b_n, en_b;

  logic       a_hs, a_vs, a_de, a_fr, a_ls, a_fs;
  logic [9:0] a_px, a_py, a_fx, a_fy;
  logic [1:0] a_hph, a_vph;
  logic       b_hs, b_vs, b_de, b_fr, b_ls, b_fs;
  logic [9:0] b_px, b_py, b_fx, b_fy;
  logic [1:0] b_hph, b_vph;

  vga_timing_ctrl dut_a (
    .CLK(clk), .Reset(rst_a_n), .Enable(en_a),
    .HSync(a_hs), .VSync(a_vs), .DispEn(a_de),
    .PixX(a_px), .PixY(a_py),
    .FetchReq(a_fr), .FetchX(a_fx), .FetchY(a_fy),
    .LineStart(a_ls), .FrameStart(a_fs),
    .HPhase(a_hph), .VPhase(a_vph)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1),  .FETCH_LEAD(2)
  ) dut_b (
    .CLK(clk), .Reset(rst_b_n), .Enable(en_b),
    .HSync(b_hs), .VSync(b_vs), .DispEn(b_de),
    .PixX(b_px), .PixY(b_py),
    .FetchReq(b_fr), .FetchX(b_fx), .FetchY(b_fy),
    .LineStart(b_ls), .FrameStart(b_fs),
    .HPhase(b_hph), .VPhase(b_vph)
  );

  // ---------------- observation / reference model ----------------
  typedef struct packed {
    logic       hs, vs, de, ls, fs;
    logic [1:0] hph, vph;
    logic       fr;
    logic [9:0] px, py, fx, fy;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {a_hs, a_vs, a_de, a_ls, a_fs, a_hph, a_vph, a_fr, a_px, a_py, a_fx, a_fy};
  assign obs_b = {b_hs, b_vs, b_de, b_ls, b_fs, b_hph, b_vph, b_fr, b_px, b_py, b_fx, b_fy};

  // Expected outputs for a running raster at (col,row), from the timing windows.
  function automatic obs_t model(input int col, input int row,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input int pol, input int lead);
    obs_t o;
    int ht, vt, s, fx, fy;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    o  = '0;
    if (col < ha) o.hph = 2'd0;
    else if (col < ha + hfp) o.hph = 2'd1;
    else if (col < ha + hfp + hsw) o.hph = 2'd2;
    else o.hph = 2'd3;
    if (row < va) o.vph = 2'd0;
    else if (row < va + vfp) o.vph = 2'd1;
    else if (row < va + vfp + vsw) o.vph = 2'd2;
    else o.vph = 2'd3;
    o.hs = (o.hph == 2'd2) ? pol[0] : ~pol[0];
    o.vs = (o.vph == 2'd2) ? pol[0] : ~pol[0];
    o.de = (o.hph == 2'd0) && (o.vph == 2'd0);
    o.ls = (col == 0);
    o.fs = (col == 0) && (row == 0);
    o.px = 10'(col);
    o.py = 10'(row);
    s = col + lead;
    if (s >= ht) begin
      fx = s - ht;
      fy = (row + 1) % vt;
    end else begin
      fx = s;
      fy = row;
    end
    o.fx = 10'(fx);
    o.fy = 10'(fy);
    o.fr = (fx < ha) && (fy < va);
    return o;
  endfunction

  function automatic obs_t model_a(input int cyc);
    return model(cyc % 800, (cyc / 800) % 525, 640, 16, 96, 48, 480, 10, 2, 33, 0, 2);
  endfunction

  function automatic obs_t model_b(input int cyc);
    return model(cyc % 30, (cyc / 30) % 15, 16, 4, 6, 4, 8, 2, 2, 3, 1, 2);
  endfunction

  // ---------------- scoreboard state ----------------
  int compared   = 0;
  int mismatched = 0;
  int a_cyc      = 0;          // samples since instance a last started a frame
  logic [39:0] exp_q[$];       // {due_cycle[19:0], x[9:0], y[9:0]} pending fetches

  // Sample point: 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t e;
    rst_a_n = 1'b0; en_a = 1'b0;
    rst_b_n = 1'b0; en_b = 1'b0;
    #23;
    e = '0; e.hs = 1'b1; e.vs = 1'b1;
    compared++;
    if (obs_a !== e) begin
      mismatched++;
      $display("FAIL reset_a: got %h want %h", obs_a, e);
    end
    e = '0;
    compared++;
    if (obs_b !== e) begin
      mismatched++;
      $display("FAIL reset_b_pol1: got %h want %h", obs_b, e);
    end
    en_a = 1'b1;
    tick();
    e = '0; e.hs = 1'b1; e.vs = 1'b1;
    compared++;
    if (obs_a !== e) begin
      mismatched++;
      $display("FAIL reset_held_a: got %h want %h", obs_a, e);
    end
  endtask

  // Releases reset on instance a (caller sits just after an edge, Enable=1)
  // and checks the first line plus the wrap into line 1.
  task automatic test_first_line();
    obs_t e;
    int hs_low, de_cnt;
    hs_low = 0; de_cnt = 0;
    rst_a_n = 1'b1;
    for (int k = 0; k <= 800; k++) begin
      tick();
      a_cyc = k;
      e = model_a(k);
      compared++;
      if (obs_a !== e) begin
        mismatched++;
        $display("FAIL first_line k=%0d: got %h want %h", k, obs_a, e);
      end
      if (k < 800) begin
        if (a_hs == 1'b0) hs_low++;
        if (a_de == 1'b1) de_cnt++;
      end
      if (k == 637) begin
        compared++;
        if ({a_fr, a_fx, a_fy} !== {1'b1, 10'd639, 10'd0}) begin
          mismatched++;
          $display("FAIL fetch_639_0: got %b/%0d/%0d want 1/639/0", a_fr, a_fx, a_fy);
        end
      end
      if (k == 798) begin
        compared++;
        if ({a_fr, a_fx, a_fy} !== {1'b1, 10'd0, 10'd1}) begin
          mismatched++;
          $display("FAIL fetch_0_1: got %b/%0d/%0d want 1/0/1", a_fr, a_fx, a_fy);
        end
      end
      if (k == 799) begin
        compared++;
        if ({a_fr, a_fx, a_fy} !== {1'b1, 10'd1, 10'd1}) begin
          mismatched++;
          $display("FAIL fetch_1_1: got %b/%0d/%0d want 1/1/1", a_fr, a_fx, a_fy);
        end
      end
    end
    compared++;
    if (hs_low != 96) begin
      mismatched++;
      $display("FAIL hsync_width: got %0d want 96", hs_low);
    end
    compared++;
    if (de_cnt != 640) begin
      mismatched++;
      $display("FAIL line_de_count: got %0d want 640", de_cnt);
    end
  endtask

  // Drop Enable at (300,1) for 5 cycles, then restart.
  task automatic test_enable_gap();
    obs_t e;
    while (a_cyc < 1100) begin
      tick();
      a_cyc++;
      e = model_a(a_cyc);
      compared++;
      if (obs_a !== e) begin
        mismatched++;
        $display("FAIL pre_gap cyc=%0d: got %h want %h", a_cyc, obs_a, e);
      end
    end
    en_a = 1'b0;
    e = '0; e.hs = 1'b1; e.vs = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      // FetchX/FetchY are don't-care while blanked.
      compared++;
      if (obs_a[49:20] !== e[49:20]) begin
        mismatched++;
        $display("FAIL gap_blank k=%0d: got %h want %h", k, obs_a[49:20], e[49:20]);
      end
    end
    en_a = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      a_cyc = k;
      e = model_a(k);
      compared++;
      if (obs_a !== e) begin
        mismatched++;
        $display("FAIL restart k=%0d: got %h want %h", k, obs_a, e);
      end
    end
  endtask

  // Assert Reset between edges while HSync is active at Col=700.
  task automatic test_reset_mid_hsync();
    obs_t e;
    while ((a_cyc % 800) != 700) begin
      tick();
      a_cyc++;
      e = model_a(a_cyc);
      compared++;
      if (obs_a !== e) begin
        mismatched++;
        $display("FAIL to_col700 cyc=%0d: got %h want %h", a_cyc, obs_a, e);
      end
    end
    compared++;
    if (a_hs !== 1'b0) begin
      mismatched++;
      $display("FAIL hsync_at_700: got %b want 0", a_hs);
    end
    #1;
    rst_a_n = 1'b0;
    #1;
    e = '0; e.hs = 1'b1; e.vs = 1'b1;
    compared++;
    if (obs_a !== e) begin
      mismatched++;
      $display("FAIL async_reset: got %h want %h", obs_a, e);
    end
    tick();
    test_first_line();
  endtask

  // Small raster, active-high syncs: two frames of checks plus the
  // fetch-to-pixel guarantee across line and frame wraps.
  task automatic test_small_frame();
    obs_t e;
    int first_vs, vs_cnt, de_cnt, fs_cnt, pops, c, r;
    logic [39:0] ent;
    logic popped;
    first_vs = -1; vs_cnt = 0; de_cnt = 0; fs_cnt = 0; pops = 0;
    en_b = 1'b1;
    rst_b_n = 1'b1;
    for (int cyc = 0; cyc <= 901; cyc++) begin
      tick();
      c = cyc % 30;
      r = (cyc / 30) % 15;
      e = model_b(cyc);
      compared++;
      if (obs_b !== e) begin
        mismatched++;
        $display("FAIL small_frame cyc=%0d: got %h want %h", cyc, obs_b, e);
      end
      if (b_vs == 1'b1 && first_vs < 0) first_vs = cyc;
      if (cyc >= 450 && cyc < 900) begin
        if (b_vs == 1'b1) vs_cnt++;
        if (b_de == 1'b1) de_cnt++;
        if (b_fs == 1'b1) fs_cnt++;
      end
      if (r == 7 && c == 28 && cyc < 450) begin
        compared++;
        if ({b_fr, b_fy} !== {1'b0, 10'd8}) begin
          mismatched++;
          $display("FAIL no_fetch_last_line: got %b/%0d want 0/8", b_fr, b_fy);
        end
      end
      if (r == 14 && c == 28) begin
        compared++;
        if ({b_fr, b_fx, b_fy} !== {1'b1, 10'd0, 10'd0}) begin
          mismatched++;
          $display("FAIL fetch_frame_wrap: got %b/%0d/%0d want 1/0/0", b_fr, b_fx, b_fy);
        end
      end
      popped = 1'b0;
      if (exp_q.size() > 0) begin
        if (exp_q[0][39:20] == 20'(cyc)) begin
          ent = exp_q.pop_front();
          popped = 1'b1;
          pops++;
          compared++;
          if ({b_de, b_px, b_py} !== {1'b1, ent[19:10], ent[9:0]}) begin
            mismatched++;
            $display("FAIL fetch_lead cyc=%0d: got de=%b (%0d,%0d) want de=1 (%0d,%0d)",
                     cyc, b_de, b_px, b_py, ent[19:10], ent[9:0]);
          end
        end
      end
      if (b_de == 1'b1 && cyc >= 452 && !popped) begin
        compared++;
        mismatched++;
        $display("FAIL unfetched_pixel cyc=%0d: got (%0d,%0d) want a fetch 2 cycles earlier",
                 cyc, b_px, b_py);
      end
      if (cyc >= 450 && cyc < 900 && b_fr == 1'b1)
        exp_q.push_back({20'(cyc + 2), b_fx, b_fy});
    end
    compared++;
    if (first_vs != 300) begin
      mismatched++;
      $display("FAIL vsync_start: got %0d want 300", first_vs);
    end
    compared++;
    if (vs_cnt != 60) begin
      mismatched++;
      $display("FAIL vsync_width: got %0d want 60", vs_cnt);
    end
    compared++;
    if (de_cnt != 128) begin
      mismatched++;
      $display("FAIL frame_de_count: got %0d want 128", de_cnt);
    end
    compared++;
    if (fs_cnt != 1) begin
      mismatched++;
      $display("FAIL framestart_count: got %0d want 1", fs_cnt);
    end
    compared++;
    if (pops != 128 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL fetch_count: got %0d pops %0d left want 128 pops 0 left", pops, exp_q.size());
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_first_line();
    test_enable_gap();
    test_reset_mid_hsync();
    test_small_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
